rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the register file's single write port between the in-order writeback stage and the multi-cycle multiply/divide unit (MDU). Writeback always has priority. MDU results are buffered in a small FIFO and committed in idle write slots. A 32-entry pending scoreboard tells the hazard unit which source registers still await an MDU result. The block sits between writeback/MDU and `register_file`, driving that module's WEN/wsel/wdat.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: MDU result buffer entries; power of two, ≥2.
- `STARVE_LIMIT`, 4: consecutive blocked cycles of a non-empty FIFO before `stall_req` asserts; ≥1.

Ports:
- `CLK` in 1: clock; all state updates on posedge.
- `nRST` in 1: reset, asynchronous, active-low.
- `wb_wen` in 1: writeback write request; never back-pressured.
- `wb_wsel` in 5: writeback destination.
- `wb_wdat` in 32: writeback data.
- `mdu_valid` in 1: MDU result valid.
- `mdu_ready` out 1: FIFO can accept an MDU result.
- `mdu_wsel` in 5: MDU destination.
- `mdu_wdat` in 32: MDU data.
- `issue_en` in 1: long-latency op issued this cycle.
- `issue_wsel` in 5: destination of the issued op.
- `rs_sel` in 5, `rt_sel` in 5: decode-stage source registers.
- `rs_busy` out 1, `rt_busy` out 1: source register has a pending MDU write.
- `rf_wen` out 1: register file write enable.
- `rf_wsel` out 5: register file write select.
- `rf_wdat` out 32: register file write data.
- `stall_req` out 1: request to the hazard unit to hold writeback idle.
- `fifo_count` out log2(FIFO_DEPTH)+1: occupancy.

## Operation
- **wb_act** = `wb_wen` && `wb_wsel` != 0. Writeback with `wsel` 0 counts as no request.
- **Output mux:** `rf_*` are combinational.
  - If wb_act: `rf_wen`=1 and `rf_wsel`/`rf_wdat` = the `wb_*` values.
  - Else if the FIFO is non-empty: the FIFO head drives `rf_*`. `rf_wen` = (head.wsel != 0).
  - Else: `rf_wen`=0, `rf_wsel`=0, `rf_wdat`=0.
- **Push:** occurs when `mdu_valid` && `mdu_ready`. `mdu_ready` = !full; it never depends on a same-cycle pop.
- **Pop:** occurs when the FIFO is non-empty && !wb_act.
- **Simultaneous push and pop:** count is unchanged and both pointers advance.
- **Pointers:** wrap modulo `FIFO_DEPTH`.
- **Scoreboard:** a 32-bit `pending` vector.
  - Set: `issue_en` && `issue_wsel` != 0 sets bit `issue_wsel`.
  - Clear: a pop clears bit head.wsel.
  - Same cycle, same register: set wins.
  - Bit 0 is always 0.
  - Writeback writes never clear bits.
- **Busy outputs:** `rs_busy` = `pending[rs_sel]` and `rt_busy` = `pending[rt_sel]`, both combinational.
- **Starvation counter:**
  - Increments each cycle the FIFO is non-empty and wb_act is high.
  - Resets to 0 on any pop or when the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
- **stall_req:** registered. It becomes 1 the cycle after the counter reaches `STARVE_LIMIT` or the FIFO becomes full. It becomes 0 the cycle after a pop. The hazard unit guarantees wb_act=0 while `stall_req` is 1.

## Timing
- **Reset values** while `nRST` is low: FIFO empty, `fifo_count`=0, `pending`=0, starve counter 0, `stall_req`=0, `mdu_ready`=0, `rf_wen`=0, `rf_wsel`=0, `rf_wdat`=0, `rs_busy`=0, `rt_busy`=0. `mdu_ready` goes to 1 in the first cycle after release.
- **Reset mid-operation:** discards buffered results and all pending bits; no partial write is emitted.
- **Latency, MDU accept to commit:** 1 cycle minimum. The entry is accepted at posedge N, drives `rf_*` during cycle N+1, and `register_file` captures it on the falling edge of cycle N+1.
- **Latency, pending bit:** visible the cycle after `issue_en`. It is cleared the cycle after the pop cycle.
- **Latency, writeback:** zero-cycle pass-through; the write lands on the same cycle's falling edge.
- **Full boundary:** with the FIFO full, `mdu_ready`=0 even if a pop occurs in the same cycle. It rises the cycle after the pop.

## Structure
- **`cpu_types_pkg`:** add `regbits_t` (5-bit register index) if absent. Add `rf_wreq_t` as a packed struct of {`regbits_t wsel`, `word_t wdat`}, used for the FIFO entries and `wb_*`/`mdu_*` bundling.
- **New interface:** `rf_write_arbiter_if.vh` with modports `arb` and `tb`.
- **Sub-module `rf_wb_fifo`:**
  - Parameterised depth; stores `rf_wreq_t`.
  - Ports: push, pop, full, empty, count, head.
  - The arbiter instantiates it once; scoreboard and starvation logic stay in the top.

## Test plan
- **Reset:** hold `nRST`=0 with `mdu_valid`=1 and `issue_en`=1 → all outputs at reset values, `mdu_ready`=0; after release `mdu_ready`=1 and `fifo_count`=0.
- **Idle-slot commit:** `issue_en`, `issue_wsel`=9 at cycle 0, so `rs_busy`=1 for `rs_sel`=9 from cycle 1. MDU pushes {9, 0xDEADBEEF} at cycle 3 with `wb_wen`=0 → `rf_wen`=1, `rf_wsel`=9, `rf_wdat`=0xDEADBEEF in cycle 4; `rs_busy`=0 from cycle 5.
- **Priority and starvation:** with `wb_wen`=1 to reg 3 every cycle, push {5, 0x1} → `rf_wsel` stays 3. `stall_req`=1 after 4 blocked cycles. Drop `wb_wen` → entry 5 commits that cycle and `stall_req`=0 the next.
- **Full and wrap:** with writeback busy, push 2 entries → `mdu_ready`=0 and `stall_req`=1. Then drain and push 6 more in alternating cycles → commits appear in FIFO order, pointer wrap is exercised, and no entry is lost or duplicated.
- **$0 handling:** `wb_wen`=1, `wb_wsel`=0 with the FIFO holding {7, 0x2} → entry 7 commits. An MDU push {0, 0x3} → pops with `rf_wen`=0; `issue_wsel`=0 never sets `pending`.
- **Set/clear collision:** pop of reg 12 and `issue_en` to reg 12 in the same cycle → `pending[12]` remains 1.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: register index, data word
// and the {wsel, wdat} write request carried by writeback, the MDU and the FIFO.
package rf_write_arbiter_pkg;

   typedef logic [4:0]  regbits_t;
   typedef logic [31:0] word_t;

   typedef struct packed {
      regbits_t wsel;
      word_t    wdat;
   } rf_wreq_t;

   localparam int NUM_REGS = 32;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small circular buffer holding MDU write requests until an idle write slot
// lets the arbiter commit them; head is the oldest entry.
module rf_wb_fifo
   import rf_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     push,
   input  logic                     pop,
   input  rf_wreq_t                 push_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output rf_wreq_t                 head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   rf_wreq_t         mem_q [DEPTH];
   rf_wreq_t         mem_d [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = mem_q[rptr_q];

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) begin
         mem_d[wptr_q] = push_data;
         wptr_d        = wptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rptr_d = rptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port between writeback (always first) and
// buffered MDU results, tracking pending MDU destinations for the hazard unit.
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                          CLK,
   input  logic                          nRST,
   input  logic                          wb_wen,
   input  logic [4:0]                    wb_wsel,
   input  logic [31:0]                   wb_wdat,
   input  logic                          mdu_valid,
   output logic                          mdu_ready,
   input  logic [4:0]                    mdu_wsel,
   input  logic [31:0]                   mdu_wdat,
   input  logic                          issue_en,
   input  logic [4:0]                    issue_wsel,
   input  logic [4:0]                    rs_sel,
   input  logic [4:0]                    rt_sel,
   output logic                          rs_busy,
   output logic                          rt_busy,
   output logic                          rf_wen,
   output logic [4:0]                    rf_wsel,
   output logic [31:0]                   rf_wdat,
   output logic                          stall_req,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   logic                  wb_act;
   logic                  push;
   logic                  pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   rf_wreq_t              fifo_head;
   rf_wreq_t              mdu_req;
   logic [NUM_REGS-1:0]   pending_q, pending_d;
   logic [STARVE_W-1:0]   starve_q, starve_d;
   logic                  stall_q, stall_d;

   // Gating with nRST keeps writeback from leaking onto the port during reset.
   assign wb_act    = nRST && wb_wen && (wb_wsel != 5'd0);
   assign mdu_ready = nRST && !fifo_full;
   assign push      = mdu_valid && mdu_ready;
   assign pop       = !fifo_empty && !wb_act;
   assign mdu_req   = '{wsel: mdu_wsel, wdat: mdu_wdat};

   rf_wb_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .nRST      (nRST),
      .push      (push),
      .pop       (pop),
      .push_data (mdu_req),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   always_comb begin
      rf_wen  = 1'b0;
      rf_wsel = 5'd0;
      rf_wdat = 32'd0;
      if (wb_act) begin
         rf_wen  = 1'b1;
         rf_wsel = wb_wsel;
         rf_wdat = wb_wdat;
      end else if (!fifo_empty) begin
         rf_wen  = (fifo_head.wsel != 5'd0);
         rf_wsel = fifo_head.wsel;
         rf_wdat = fifo_head.wdat;
      end
   end

   assign rs_busy   = pending_q[rs_sel];
   assign rt_busy   = pending_q[rt_sel];
   assign stall_req = stall_q;

   // A new issue to the register being popped must stay pending, so set follows clear.
   always_comb begin
      pending_d = pending_q;
      if (pop) begin
         pending_d[fifo_head.wsel] = 1'b0;
      end
      if (issue_en && (issue_wsel != 5'd0)) begin
         pending_d[issue_wsel] = 1'b1;
      end
      pending_d[0] = 1'b0;

      starve_d = starve_q;
      if (fifo_empty || pop) begin
         starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
         starve_d = starve_q + STARVE_W'(1);
      end

      stall_d = !pop && (stall_q || (starve_d == STARVE_MAX) || fifo_full);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pending_q <= '0;
         starve_q  <= '0;
         stall_q   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         starve_q  <= starve_d;
         stall_q   <= stall_d;
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter: one task per scenario,
// expected values worked out by hand from cycle-by-cycle behaviour.
module tb_rf_write_arbiter;

   logic        CLK;
   logic        nRST;
   logic        wb_wen;
   logic [4:0]  wb_wsel;
   logic [31:0] wb_wdat;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_wsel;
   logic [31:0] mdu_wdat;
   logic        issue_en;
   logic [4:0]  issue_wsel;
   logic [4:0]  rs_sel;
   logic [4:0]  rt_sel;
   logic        rs_busy;
   logic        rt_busy;
   logic        rf_wen;
   logic [4:0]  rf_wsel;
   logic [31:0] rf_wdat;
   logic        stall_req;
   logic [1:0]  fifo_count;

   int tests_run;
   int tests_failed;

   rf_write_arbiter #(
      .FIFO_DEPTH   (2),
      .STARVE_LIMIT (4)
   ) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .wb_wen     (wb_wen),
      .wb_wsel    (wb_wsel),
      .wb_wdat    (wb_wdat),
      .mdu_valid  (mdu_valid),
      .mdu_ready  (mdu_ready),
      .mdu_wsel   (mdu_wsel),
      .mdu_wdat   (mdu_wdat),
      .issue_en   (issue_en),
      .issue_wsel (issue_wsel),
      .rs_sel     (rs_sel),
      .rt_sel     (rt_sel),
      .rs_busy    (rs_busy),
      .rt_busy    (rt_busy),
      .rf_wen     (rf_wen),
      .rf_wsel    (rf_wsel),
      .rf_wdat    (rf_wdat),
      .stall_req  (stall_req),
      .fifo_count (fifo_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Each cycle: move just past the edge, drive inputs, then sample 1 ns later.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      wb_wen = 1'b1; wb_wsel = 5'd3; wb_wdat = 32'h1234;
      mdu_valid = 1'b1; mdu_wsel = 5'd4; mdu_wdat = 32'h5;
      issue_en = 1'b1; issue_wsel = 5'd5; rs_sel = 5'd5; rt_sel = 5'd4;
      repeat (3) step();
      #1;
      tests_run++; if (mdu_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mdu_ready: got %0b expected 0", mdu_ready); end
      tests_run++; if (fifo_count !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
      tests_run++; if (rf_wen !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rf_wen: got %0b expected 0", rf_wen); end
      tests_run++; if (rf_wsel !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_rf_wsel: got %0d expected 0", rf_wsel); end
      tests_run++; if (rf_wdat !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_rf_wdat: got %h expected 0", rf_wdat); end
      tests_run++; if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got rs=%0b rt=%0b expected 0/0", rs_busy, rt_busy); end
      tests_run++; if (stall_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall: got %0b expected 0", stall_req); end
      wb_wen = 1'b0; wb_wsel = 5'd0; wb_wdat = 32'd0;
      mdu_valid = 1'b0; mdu_wsel = 5'd0; mdu_wdat = 32'd0;
      issue_en = 1'b0; issue_wsel = 5'd0; rs_sel = 5'd0; rt_sel = 5'd0;
      nRST = 1'b1;
      #1;
      tests_run++; if (mdu_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL release_mdu_ready: got %0b expected 1", mdu_ready); end
      tests_run++; if (fifo_count !== 2'd0) begin tests_failed++; $display("[TB] FAIL release_count: got %0d expected 0", fifo_count); end
   endtask

   task automatic test_idle_commit();
      step();
      issue_en = 1'b1; issue_wsel = 5'd9; rs_sel = 5'd9; rt_sel = 5'd9;
      #1;
      tests_run++; if (rs_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_busy_c0: got %0b expected 0", rs_busy); end
      step();
      issue_en = 1'b0;
      #1;
      tests_run++; if (rs_busy !== 1'b1 || rt_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL idle_busy_c1: got rs=%0b rt=%0b expected 1/1", rs_busy, rt_busy); end
      step();
      step();
      mdu_valid = 1'b1; mdu_wsel = 5'd9; mdu_wdat = 32'hDEADBEEF;
      #1;
      tests_run++; if (mdu_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL idle_ready: got %0b expected 1", mdu_ready); end
      tests_run++; if (rf_wen !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_no_write_c3: got %0b expected 0", rf_wen); end
      step();
      mdu_valid = 1'b0;
      #1;
      tests_run++; if (rf_wen !== 1'b1 || rf_wsel !== 5'd9 || rf_wdat !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL idle_commit: got wen=%0b wsel=%0d wdat=%h expected 1/9/deadbeef", rf_wen, rf_wsel, rf_wdat); end
      tests_run++; if (rs_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL idle_busy_c4: got %0b expected 1", rs_busy); end
      step();
      #1;
      tests_run++; if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_busy_c5: got rs=%0b rt=%0b expected 0/0", rs_busy, rt_busy); end
      tests_run++; if (fifo_count !== 2'd0 || rf_wen !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_drained: got count=%0d wen=%0b expected 0/0", fifo_count, rf_wen); end
   endtask

   task automatic test_priority_starve();
      step();
      wb_wen = 1'b1; wb_wsel = 5'd3; wb_wdat = 32'h33;
      mdu_valid = 1'b1; mdu_wsel = 5'd5; mdu_wdat = 32'h1;
      #1;
      tests_run++; if (rf_wsel !== 5'd3 || rf_wdat !== 32'h33) begin tests_failed++; $display("[TB] FAIL prio_wb_pass: got wsel=%0d wdat=%h expected 3/33", rf_wsel, rf_wdat); end
      for (int k = 1; k <= 4; k++) begin
         step();
         mdu_valid = 1'b0;
         #1;
         tests_run++; if (rf_wsel !== 5'd3 || stall_req !== 1'b0 || fifo_count !== 2'd1) begin tests_failed++; $display("[TB] FAIL prio_blocked_%0d: got wsel=%0d stall=%0b count=%0d expected 3/0/1", k, rf_wsel, stall_req, fifo_count); end
      end
      step();
      wb_wen = 1'b0;
      #1;
      tests_run++; if (stall_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL prio_stall: got %0b expected 1", stall_req); end
      tests_run++; if (rf_wen !== 1'b1 || rf_wsel !== 5'd5 || rf_wdat !== 32'h1) begin tests_failed++; $display("[TB] FAIL prio_commit: got wen=%0b wsel=%0d wdat=%h expected 1/5/1", rf_wen, rf_wsel, rf_wdat); end
      step();
      #1;
      tests_run++; if (stall_req !== 1'b0 || fifo_count !== 2'd0) begin tests_failed++; $display("[TB] FAIL prio_release: got stall=%0b count=%0d expected 0/0", stall_req, fifo_count); end
   endtask

   task automatic test_full_wrap();
      step();
      wb_wen = 1'b1; wb_wsel = 5'd3; wb_wdat = 32'h44;
      mdu_valid = 1'b1; mdu_wsel = 5'd20; mdu_wdat = 32'h100;
      #1;
      tests_run++; if (mdu_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_ready0: got %0b expected 1", mdu_ready); end
      step();
      mdu_wsel = 5'd21; mdu_wdat = 32'h101;
      #1;
      tests_run++; if (fifo_count !== 2'd1 || rf_wsel !== 5'd3) begin tests_failed++; $display("[TB] FAIL full_one: got count=%0d wsel=%0d expected 1/3", fifo_count, rf_wsel); end
      step();
      mdu_wsel = 5'd22; mdu_wdat = 32'h102;
      #1;
      tests_run++; if (fifo_count !== 2'd2 || mdu_ready !== 1'b0 || stall_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_two: got count=%0d ready=%0b stall=%0b expected 2/0/0", fifo_count, mdu_ready, stall_req); end
      step();
      wb_wen = 1'b0;
      #1;
      tests_run++; if (stall_req !== 1'b1 || mdu_ready !== 1'b0 || fifo_count !== 2'd2) begin tests_failed++; $display("[TB] FAIL full_stall: got stall=%0b ready=%0b count=%0d expected 1/0/2", stall_req, mdu_ready, fifo_count); end
      tests_run++; if (rf_wen !== 1'b1 || rf_wsel !== 5'd20 || rf_wdat !== 32'h100) begin tests_failed++; $display("[TB] FAIL full_drain0: got wen=%0b wsel=%0d wdat=%h expected 1/20/100", rf_wen, rf_wsel, rf_wdat); end
      mdu_valid = 1'b0;
      step();
      #1;
      tests_run++; if (fifo_count !== 2'd1 || mdu_ready !== 1'b1 || stall_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_after_pop: got count=%0d ready=%0b stall=%0b expected 1/1/0", fifo_count, mdu_ready, stall_req); end
      tests_run++; if (rf_wsel !== 5'd21 || rf_wdat !== 32'h101) begin tests_failed++; $display("[TB] FAIL full_drain1: got wsel=%0d wdat=%h expected 21/101", rf_wsel, rf_wdat); end
      step();
      #1;
      tests_run++; if (fifo_count !== 2'd0 || rf_wen !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_empty: got count=%0d wen=%0b expected 0/0 (entry 22 must not be kept)", fifo_count, rf_wen); end
      for (int i = 0; i < 6; i++) begin
         step();
         mdu_valid = 1'b1; mdu_wsel = 5'(24 + i); mdu_wdat = 32'h200 + 32'(i);
         #1;
         tests_run++; if (mdu_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_ready_%0d: got %0b expected 1", i, mdu_ready); end
         step();
         mdu_valid = 1'b0;
         #1;
         tests_run++; if (rf_wen !== 1'b1 || rf_wsel !== 5'(24 + i) || rf_wdat !== 32'h200 + 32'(i) || fifo_count !== 2'd1) begin tests_failed++; $display("[TB] FAIL wrap_commit_%0d: got wen=%0b wsel=%0d wdat=%h count=%0d expected 1/%0d/%h/1", i, rf_wen, rf_wsel, rf_wdat, fifo_count, 24 + i, 32'h200 + 32'(i)); end
      end
      step();
      #1;
      tests_run++; if (fifo_count !== 2'd0) begin tests_failed++; $display("[TB] FAIL wrap_final_count: got %0d expected 0", fifo_count); end
   endtask

   task automatic test_zero_reg();
      step();
      mdu_valid = 1'b1; mdu_wsel = 5'd7; mdu_wdat = 32'h2;
      step();
      mdu_valid = 1'b0;
      wb_wen = 1'b1; wb_wsel = 5'd0; wb_wdat = 32'hAAAA;
      issue_en = 1'b1; issue_wsel = 5'd0; rs_sel = 5'd0;
      #1;
      tests_run++; if (rf_wen !== 1'b1 || rf_wsel !== 5'd7 || rf_wdat !== 32'h2) begin tests_failed++; $display("[TB] FAIL zero_wb_ignored: got wen=%0b wsel=%0d wdat=%h expected 1/7/2", rf_wen, rf_wsel, rf_wdat); end
      step();
      wb_wen = 1'b0; issue_en = 1'b0;
      mdu_valid = 1'b1; mdu_wsel = 5'd0; mdu_wdat = 32'h3;
      #1;
      tests_run++; if (rs_busy !== 1'b0 || fifo_count !== 2'd0) begin tests_failed++; $display("[TB] FAIL zero_pending: got busy=%0b count=%0d expected 0/0", rs_busy, fifo_count); end
      step();
      mdu_valid = 1'b0;
      #1;
      tests_run++; if (rf_wen !== 1'b0 || fifo_count !== 2'd1 || rf_wdat !== 32'h3) begin tests_failed++; $display("[TB] FAIL zero_mdu_pop: got wen=%0b count=%0d wdat=%h expected 0/1/3", rf_wen, fifo_count, rf_wdat); end
      step();
      #1;
      tests_run++; if (fifo_count !== 2'd0) begin tests_failed++; $display("[TB] FAIL zero_drained: got %0d expected 0", fifo_count); end
   endtask

   task automatic test_collision();
      step();
      issue_en = 1'b1; issue_wsel = 5'd12; rs_sel = 5'd12; rt_sel = 5'd12;
      step();
      issue_en = 1'b0;
      mdu_valid = 1'b1; mdu_wsel = 5'd12; mdu_wdat = 32'hC;
      #1;
      tests_run++; if (rs_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL coll_set: got %0b expected 1", rs_busy); end
      step();
      mdu_valid = 1'b0;
      issue_en = 1'b1; issue_wsel = 5'd12;
      #1;
      tests_run++; if (rf_wen !== 1'b1 || rf_wsel !== 5'd12) begin tests_failed++; $display("[TB] FAIL coll_pop: got wen=%0b wsel=%0d expected 1/12", rf_wen, rf_wsel); end
      step();
      issue_en = 1'b0;
      mdu_valid = 1'b1; mdu_wsel = 5'd12; mdu_wdat = 32'hD;
      #1;
      tests_run++; if (rs_busy !== 1'b1 || rt_busy !== 1'b1 || fifo_count !== 2'd0) begin tests_failed++; $display("[TB] FAIL coll_set_wins: got rs=%0b rt=%0b count=%0d expected 1/1/0", rs_busy, rt_busy, fifo_count); end
      step();
      mdu_valid = 1'b0;
      step();
      #1;
      tests_run++; if (rs_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL coll_cleared: got %0b expected 0", rs_busy); end
   endtask

   task automatic test_reset_mid();
      step();
      wb_wen = 1'b1; wb_wsel = 5'd3; wb_wdat = 32'h55;
      mdu_valid = 1'b1; mdu_wsel = 5'd15; mdu_wdat = 32'hF;
      issue_en = 1'b1; issue_wsel = 5'd15; rs_sel = 5'd15;
      step();
      mdu_valid = 1'b0; issue_en = 1'b0;
      #1;
      tests_run++; if (fifo_count !== 2'd1 || rs_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_before: got count=%0d busy=%0b expected 1/1", fifo_count, rs_busy); end
      nRST = 1'b0;
      #1;
      tests_run++; if (fifo_count !== 2'd0 || rs_busy !== 1'b0 || rf_wen !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_reset: got count=%0d busy=%0b wen=%0b expected 0/0/0", fifo_count, rs_busy, rf_wen); end
      wb_wen = 1'b0;
      step();
      nRST = 1'b1;
      step();
      #1;
      tests_run++; if (rf_wen !== 1'b0 || fifo_count !== 2'd0 || stall_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_after: got wen=%0b count=%0d stall=%0b expected 0/0/0", rf_wen, fifo_count, stall_req); end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_idle_commit();
      test_priority_starve();
      test_full_wrap();
      test_zero_reg();
      test_collision();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
